// File: rtl/mult_div_unit_pkg.sv
// Shared op codes and default latencies for the HI/LO multiply/divide unit.
package mult_div_unit_pkg;

  localparam logic [2:0] OpMult  = 3'd0;
  localparam logic [2:0] OpMultu = 3'd1;
  localparam logic [2:0] OpDiv   = 3'd2;
  localparam logic [2:0] OpDivu  = 3'd3;

  localparam int unsigned MduMultCycles = 5;
  localparam int unsigned MduDivCycles  = 10;

endpackage

// File: rtl/mult_div_unit.sv
// EX-stage multiply/divide unit with fixed-latency busy counter and HI/LO registers.
// Optional exception-flush input enabled by defining MDU_CANCEL_EN.
module mult_div_unit
  import mult_div_unit_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = MduMultCycles,
  parameter int unsigned DIV_CYCLES  = MduDivCycles
) (
  input  logic        clk,
  input  logic        reset,
`ifdef MDU_CANCEL_EN
  input  logic        cancel,
`endif
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        mthi,
  input  logic        mtlo,
  input  logic        mfhi,
  input  logic        mflo,
  output logic        busy,
  output logic [31:0] rdata,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int unsigned MaxCycles = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CntW      = $clog2(MaxCycles + 1);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic [31:0]     hi_q, hi_d, lo_q, lo_d;
  logic [63:0]     pend_q, pend_d;
  logic            pend_valid_q, pend_valid_d;

  logic            is_mul, is_div;
  logic [31:0]     b_nz;
  logic [63:0]     result;
  logic            cancel_now;

`ifdef MDU_CANCEL_EN
  assign cancel_now = cancel;
`else
  assign cancel_now = 1'b0;
`endif

  // Divisor forced non-zero so the datapath never produces X; the result is dropped anyway.
  always_comb begin
    is_mul = (op == OpMult) || (op == OpMultu);
    is_div = (op == OpDiv) || (op == OpDivu);
    b_nz   = (b == 32'd0) ? 32'd1 : b;
    result = '0;
    case (op)
      OpMult:  result = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
      OpMultu: result = {32'd0, a} * {32'd0, b};
      OpDiv:   result = {32'($signed(a) % $signed(b_nz)), 32'($signed(a) / $signed(b_nz))};
      OpDivu:  result = {a % b_nz, a / b_nz};
      default: result = '0;
    endcase
  end

  always_comb begin
    cnt_d        = cnt_q;
    hi_d         = hi_q;
    lo_d         = lo_q;
    pend_d       = pend_q;
    pend_valid_d = pend_valid_q;
    if (cancel_now) begin
      cnt_d        = '0;
      pend_valid_d = 1'b0;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
      if (cnt_q == CntW'(1) && pend_valid_q) begin
        hi_d = pend_q[63:32];
        lo_d = pend_q[31:0];
      end
    end else if (start) begin
      // Start wins over a same-cycle mthi/mtlo; invalid op codes leave the counter idle.
      if (is_mul || is_div) begin
        cnt_d        = is_mul ? CntW'(MULT_CYCLES) : CntW'(DIV_CYCLES);
        pend_d       = result;
        pend_valid_d = !(is_div && (b == 32'd0));
      end
    end else begin
      if (mthi) hi_d = a;
      if (mtlo) lo_d = a;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q        <= '0;
      hi_q         <= '0;
      lo_q         <= '0;
      pend_q       <= '0;
      pend_valid_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      hi_q         <= hi_d;
      lo_q         <= lo_d;
      pend_q       <= pend_d;
      pend_valid_q <= pend_valid_d;
    end
  end

  assign busy  = (cnt_q != '0);
  assign hi    = hi_q;
  assign lo    = lo_q;
  assign rdata = mfhi ? hi_q : (mflo ? lo_q : 32'd0);

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed scenarios plus randomized ops vs a reference model.
module tb_mult_div_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a, b;
  logic        mthi, mtlo, mfhi, mflo;
  logic        busy;
  logic [31:0] rdata, hi, lo;
`ifdef MDU_CANCEL_EN
  logic        cancel = 1'b0;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] exp_hi, exp_lo;

  always #5 clk = ~clk;

  mult_div_unit dut (
    .clk   (clk),
    .reset (reset),
`ifdef MDU_CANCEL_EN
    .cancel(cancel),
`endif
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .mthi  (mthi),
    .mtlo  (mtlo),
    .mfhi  (mfhi),
    .mflo  (mflo),
    .busy  (busy),
    .rdata (rdata),
    .hi    (hi),
    .lo    (lo)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    start = 1'b0; op = 3'd0; a = '0; b = '0;
    mthi = 1'b0; mtlo = 1'b0; mfhi = 1'b0; mflo = 1'b0;
  endtask

  // Architectural result of an op, from the ISA definition; divide by zero keeps prior values.
  task automatic model(input logic [2:0] mop, input logic [31:0] ma, input logic [31:0] mb,
                       inout logic [31:0] mhi, inout logic [31:0] mlo);
    int sa, sb;
    longint sp;
    longint unsigned up;
    sa = ma; sb = mb;
    case (mop)
      3'd0: begin sp = longint'(sa) * longint'(sb); mhi = sp[63:32]; mlo = sp[31:0]; end
      3'd1: begin
        up = longint'({32'd0, ma}) * longint'({32'd0, mb});
        mhi = up[63:32]; mlo = up[31:0];
      end
      3'd2: if (mb != 0) begin mlo = sa / sb; mhi = sa % sb; end
      3'd3: if (mb != 0) begin mlo = ma / mb; mhi = ma % mb; end
      default: ;
    endcase
  endtask

  // Launch one op and count busy cycles; returns the observed count.
  task automatic launch(input logic [2:0] lop, input logic [31:0] la, input logic [31:0] lb,
                        output int cycles);
    start = 1'b1; op = lop; a = la; b = lb;
    step();
    idle_inputs();
    cycles = 0;
    while (busy && cycles < 40) begin
      cycles++;
      step();
    end
  endtask

  task automatic check_hilo(input string name, input logic [31:0] ehi, input logic [31:0] elo);
    n_cmp++;
    if (hi !== ehi || lo !== elo) begin
      n_bad++;
      $display("FAIL %s: hi=%h lo=%h expected hi=%h lo=%h", name, hi, lo, ehi, elo);
    end
  endtask

  task automatic check_busy_len(input string name, input int got, input int want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s busy cycles: got %0d expected %0d", name, got, want);
    end
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b0;
    step(); step();
    n_cmp++;
    if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0 || rdata !== 32'd0) begin
      n_bad++;
      $display("FAIL reset: busy=%b hi=%h lo=%h rdata=%h expected 0", busy, hi, lo, rdata);
    end
    reset = 1'b1;
    step();
    exp_hi = 0; exp_lo = 0;
  endtask

  task automatic test_mult();
    int n;
    launch(3'd0, 32'hFFFFFFFD, 32'd5, n);
    check_busy_len("mult", n, 5);
    check_hilo("mult", 32'hFFFFFFFF, 32'hFFFFFFF1);
    launch(3'd1, 32'hFFFFFFFF, 32'd2, n);
    check_busy_len("multu", n, 5);
    check_hilo("multu", 32'h00000001, 32'hFFFFFFFE);
  endtask

  task automatic test_div();
    int n;
    launch(3'd2, 32'hFFFFFFF9, 32'd2, n);
    check_busy_len("div", n, 10);
    check_hilo("div", 32'hFFFFFFFF, 32'hFFFFFFFD);
    launch(3'd3, 32'd7, 32'd2, n);
    check_busy_len("divu", n, 10);
    check_hilo("divu", 32'd1, 32'd3);
    launch(3'd3, 32'd99, 32'd0, n);
    check_busy_len("divu_by_zero", n, 10);
    check_hilo("divu_by_zero", 32'd1, 32'd3);
  endtask

  task automatic test_busy_writes();
    int n;
    mthi = 1'b1; a = 32'h12345678;
    step();
    idle_inputs();
    check_hilo("mthi_idle", 32'h12345678, 32'd3);
    // Start a multu, then try mtlo and a second start while busy.
    start = 1'b1; op = 3'd1; a = 32'd6; b = 32'd7;
    step();
    idle_inputs();
    mtlo = 1'b1; a = 32'hDEADBEEF;
    step();
    idle_inputs();
    start = 1'b1; op = 3'd3; a = 32'd100; b = 32'd3;
    step();
    idle_inputs();
    n = 2;
    while (busy && n < 40) begin n++; step(); end
    check_busy_len("second_start_ignored", n, 5);
    check_hilo("busy_writes", 32'd0, 32'd42);
    // Same-cycle start and mthi: the mt write is dropped.
    start = 1'b1; op = 3'd0; a = 32'd2; b = 32'd3; mthi = 1'b1;
    step();
    idle_inputs();
    n = 0;
    while (busy && n < 40) begin n++; step(); end
    check_hilo("start_beats_mthi", 32'd0, 32'd6);
  endtask

  task automatic test_invalid_op();
    for (int i = 4; i < 8; i++) begin
      start = 1'b1; op = 3'(i); a = 32'd5; b = 32'd5;
      step();
      idle_inputs();
      n_cmp++;
      if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd6) begin
        n_bad++;
        $display("FAIL invalid_op %0d: busy=%b hi=%h lo=%h expected busy=0 hi=0 lo=6",
                 i, busy, hi, lo);
      end
    end
  endtask

  task automatic test_reset_mid();
    start = 1'b1; op = 3'd3; a = 32'd50; b = 32'd7;
    step();
    idle_inputs();
    step(); step(); step();
    reset = 1'b0;
    step();
    reset = 1'b1;
    n_cmp++;
    if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
      n_bad++;
      $display("FAIL reset_mid: busy=%b hi=%h lo=%h expected all 0", busy, hi, lo);
    end
    for (int i = 0; i < 12; i++) step();
    check_hilo("reset_mid_no_write", 32'd0, 32'd0);
  endtask

  task automatic test_rdata();
    mthi = 1'b1; mtlo = 1'b1; a = 32'hAAAA0000;
    step();
    idle_inputs();
    mtlo = 1'b1; a = 32'h0000BBBB;
    step();
    idle_inputs();
    for (int i = 0; i < 4; i++) begin
      logic [31:0] want;
      mfhi = i[0]; mflo = i[1];
      #1;
      want = (i == 0) ? 32'd0 : (i == 2) ? 32'h0000BBBB : 32'hAAAA0000;
      n_cmp++;
      if (rdata !== want) begin
        n_bad++;
        $display("FAIL rdata mfhi=%b mflo=%b: got %h expected %h", mfhi, mflo, rdata, want);
      end
    end
    idle_inputs();
    exp_hi = 32'hAAAA0000; exp_lo = 32'h0000BBBB;
  endtask

  task automatic test_random();
    int n;
    logic [2:0]  rop;
    logic [31:0] ra, rb;
    for (int i = 0; i < 40; i++) begin
      rop = 3'($urandom_range(0, 3));
      ra  = $urandom();
      rb  = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom();
      if (i % 5 == 0) rb = 32'($urandom_range(1, 9));
      if (rop == 3'd2 && ra == 32'h80000000 && rb == 32'hFFFFFFFF) rb = 32'd1;
      model(rop, ra, rb, exp_hi, exp_lo);
      launch(rop, ra, rb, n);
      check_busy_len("random", n, (rop < 3'd2) ? 5 : 10);
      check_hilo("random", exp_hi, exp_lo);
    end
  endtask

  initial begin
    idle_inputs();
    reset = 1'b0;
    test_reset();
    test_mult();
    test_div();
    test_busy_writes();
    test_invalid_op();
    test_reset_mid();
    test_rdata();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
- EX-stage multiply/divide unit holding the architectural HI/LO registers.
- Consumes the decoder's MULT_DIV_START, MULT_DIV_OP, MTHI, MTLO, MFHI and MFLO controls.
- Models fixed multi-cycle latency with a busy counter.
- The ID stage stalls any HI/LO-class instruction while start or busy is high.

Parameters:
- MULT_CYCLES, 5, busy cycles after a mult/multu start
- DIV_CYCLES, 10, busy cycles after a div/divu start

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-low reset (0 = reset)
- start  in  1  launch op (MULT_DIV_START)
- op  in  3  operation code (MULT_DIV_OP); mult=0, multu=1, div=2, divu=3
- a  in  32  forwarded rs value (dividend / multiplicand; mthi/mtlo source)
- b  in  32  forwarded rt value (divisor / multiplier)
- mthi  in  1  write a into HI
- mtlo  in  1  write a into LO
- mfhi  in  1  select HI on rdata
- mflo  in  1  select LO on rdata
- busy  out  1  operation in flight
- rdata  out  32  combinational: mfhi ? HI : mflo ? LO : 0
- hi  out  32  HI register
- lo  out  32  LO register

Behaviour:
- Reset (reset==0 at an edge):
  - HI=0, LO=0, counter=0, busy=0.
  - Latched results are discarded, including mid-operation.
- Idle is counter==0. busy = (counter != 0), taken directly from the register.
- Start accepted when start=1 and busy=0:
  - Compute the 64-bit result from a and b at that edge into pending_hi/pending_lo.
  - Load counter with MULT_CYCLES (op 0/1) or DIV_CYCLES (op 2/3).
  - HI/LO are not changed at the start edge.
- mult: {HI,LO} = signed a * signed b. multu: unsigned product.
- div: LO = quotient, HI = remainder; truncate toward zero; remainder takes the sign of the dividend.
- divu: unsigned quotient and remainder.
- Divide by zero: the op runs its full latency and HI/LO remain unchanged.
- Each edge with counter>0: counter decrements. On the edge where counter goes 1→0, HI<=pending_hi and LO<=pending_lo.
- Timing: start at edge T → busy high for cycles T+1..T+N → new HI/LO visible after edge T+N, when busy is 0.
- Invalid op code with start: treated as a no-op; counter is not loaded.
- start while busy: ignored (upstream stall contract violated); the in-flight op is unaffected.
- mthi/mtlo when idle: HI or LO <= a at the edge, visible the next cycle.
- mthi/mtlo while busy: ignored.
- start and mthi/mtlo in the same cycle: start has priority; the mt write is dropped (decoder never issues both).
- mfhi and mflo both high: HI wins.

Optional Feature:
- Macro: MDU_CANCEL_EN.
- Defined:
  - Adds input port cancel (1 bit).
  - cancel=1 at an edge clears counter and discards pending results; HI/LO unchanged.
  - cancel at the completion edge (counter==1) also suppresses the HI/LO write.
  - cancel with start in the same cycle: the start is also suppressed.
  - Reserved for exception flush.
- Undefined: no cancel port; an op always completes.

Decomposition:
- constants.v gains:
  - op-code macros mult=3'd0, multu=3'd1, div=3'd2, divu=3'd3
  - default latency macros MDU_MULT_CYCLES=5, MDU_DIV_CYCLES=10
- Counter width is clog2(max(MULT_CYCLES, DIV_CYCLES)+1).
- No sub-module: the arithmetic is Verilog *, /, % at operand-latch time. A single module is sufficient.

Test Plan:
- Signed multiply: reset, then start op=0, a=0xFFFFFFFD (-3), b=5 → busy high exactly 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFF1.
- Unsigned multiply: op=1, a=0xFFFFFFFF, b=2 → after 5 busy cycles HI=0x00000001, LO=0xFFFFFFFE.
- Divides:
  - op=2, a=0xFFFFFFF9 (-7), b=2 → busy 10 cycles; LO=0xFFFFFFFD, HI=0xFFFFFFFF.
  - op=3, a=7, b=2 → LO=3, HI=1.
  - op=3 with b=0 → HI/LO keep their prior values.
- Busy-window writes:
  - mthi with a=0x12345678 while idle → HI=0x12345678 next cycle.
  - mtlo during busy → ignored.
  - Second start during busy → ignored; the first result is still written.
- Reset mid-op: start div; drive reset=0 for one edge at busy cycle 4 → busy=0, HI=LO=0; no write appears at cycle 10.
- rdata mux: HI=0xAAAA0000, LO=0x0000BBBB:
  - mfhi=1 → rdata=0xAAAA0000
  - mflo=1 → rdata=0x0000BBBB
  - neither → rdata=0
  - both → rdata=0xAAAA0000
